// File: rtl/lcd_dfa_ram_write_arbiter.sv
// Round-robin write-port arbiter for the LCD DFA lookahead data RAM, with per-requester burst lock.
// Optional forced lock release after LOCK_TIMEOUT idle cycles: define LCD_DFA_ARB_LOCK_TIMEOUT_EN.
module lcd_dfa_ram_write_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 1,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [ADDR_W-1:0]         ram_wr_address,
    output logic [DATA_W-1:0]         ram_wr_writedata,
    output logic                      ram_wr_write,
    input  logic                      ram_wr_waitrequest,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      lock_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                ready_q, ready_d;
    logic                ram_write_q, ram_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;

    logic                can_accept;
    logic                accept;
    logic                win_valid;
    logic [PTR_W-1:0]    win_idx;
    int                  scan_idx;

`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                lock_timeout_q, lock_timeout_d;
`endif

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign can_accept = ready_q & ~ram_wr_waitrequest;
    assign accept     = can_accept & win_valid;

    // Descending scan so the requester closest to the pointer is the last (winning) assignment.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        if (state_q == LOCKED) begin
            win_valid = req_write[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx = (int'(ptr_q) + k) % NUM_REQ;
                if (req_write[scan_idx]) begin
                    win_valid = 1'b1;
                    win_idx   = PTR_W'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        req_waitrequest = '1;
        if (accept) begin
            req_waitrequest[win_idx] = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        ready_d     = ready_q | ~ram_wr_waitrequest;
        ram_write_d = accept;
        addr_d      = addr_q;
        data_d      = data_q;
        grant_d     = '0;
`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
        idle_cnt_d     = idle_cnt_q;
        lock_timeout_d = 1'b0;
`endif
        if (accept) begin
            addr_d           = req_address[int'(win_idx)*ADDR_W +: ADDR_W];
            data_d           = req_writedata[int'(win_idx)*DATA_W +: DATA_W];
            grant_d[win_idx] = 1'b1;
            ptr_d            = next_ptr(win_idx);
        end
        if (can_accept) begin
            case (state_q)
                IDLE: begin
                    if (accept && req_lock[win_idx]) begin
                        state_d = LOCKED;
                        owner_d = win_idx;
`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
                        idle_cnt_d = '0;
`endif
                    end
                end
                LOCKED: begin
                    if (accept) begin
`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
                        idle_cnt_d = '0;
`endif
                        if (!req_lock[owner_q]) begin
                            state_d = IDLE;
                        end
                    end else if (!req_lock[owner_q]) begin
                        state_d = IDLE;
                    end
`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
                    // The owner sat idle for LOCK_TIMEOUT cycles: take the lock away and skip past it.
                    else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d        = IDLE;
                        lock_timeout_d = 1'b1;
                        ptr_d          = next_ptr(owner_q);
                        idle_cnt_d     = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            ram_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            ram_write_q <= ram_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            grant_q     <= grant_d;
        end
    end

`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            idle_cnt_q     <= idle_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end
    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign ram_wr_address   = addr_q;
    assign ram_wr_writedata = data_q;
    assign ram_wr_write     = ram_write_q;
    assign grant            = grant_q;
    assign busy             = (state_q == LOCKED);

endmodule

// File: tb/tb_lcd_dfa_ram_write_arbiter.sv
// Directed bench for lcd_dfa_ram_write_arbiter: reset/ready, round-robin, lock burst, stall, reset mid-lock, lock timeout.
module tb_lcd_dfa_ram_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_address;
    logic [15:0] req_writedata;
    logic [1:0]  req_write;
    logic [1:0]  req_lock;
    logic [1:0]  req_waitrequest;
    logic [0:0]  ram_wr_address;
    logic [7:0]  ram_wr_writedata;
    logic        ram_wr_write;
    logic        ram_wr_waitrequest;
    logic [1:0]  grant;
    logic        busy;
    logic        lock_timeout;

    int vectors    = 0;
    int miscompares = 0;

    lcd_dfa_ram_write_arbiter #(
        .NUM_REQ(2), .ADDR_W(1), .DATA_W(8), .LOCK_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_writedata(req_writedata),
        .req_write(req_write), .req_lock(req_lock),
        .req_waitrequest(req_waitrequest),
        .ram_wr_address(ram_wr_address), .ram_wr_writedata(ram_wr_writedata),
        .ram_wr_write(ram_wr_write), .ram_wr_waitrequest(ram_wr_waitrequest),
        .grant(grant), .busy(busy), .lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ram_wr_waitrequest = 1'b1;
        req_address = 2'b10; req_writedata = 16'h005A; req_write = 2'b01; req_lock = 2'b00;
        tick();
        vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL rst_wait got %b exp 11", req_waitrequest); end
        vectors++; if (ram_wr_write !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_write got %b exp 0", ram_wr_write); end
        vectors++; if ({grant, busy, lock_timeout} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rst_flags got %b exp 0000", {grant, busy, lock_timeout}); end
        vectors++; if (ram_wr_writedata !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data got %h exp 00", ram_wr_writedata); end
        reset_n = 1'b1;
        tick();
        vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL notready_wait got %b exp 11", req_waitrequest); end
        ram_wr_waitrequest = 1'b0;
        #1;
        vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL ready_lag got %b exp 11", req_waitrequest); end
        tick();
        #1;
        vectors++; if (req_waitrequest !== 2'b10) begin miscompares++; $display("[TB] FAIL first_accept got %b exp 10", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_address, ram_wr_writedata, grant} !== {1'b1, 1'b0, 8'h5A, 2'b01}) begin
            miscompares++; $display("[TB] FAIL first_write got w=%b a=%b d=%h g=%b exp w=1 a=0 d=5a g=01", ram_wr_write, ram_wr_address, ram_wr_writedata, grant);
        end
        req_write = 2'b00;
        tick();
        vectors++; if ({ram_wr_write, grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL idle_write got w=%b g=%b exp w=0 g=00", ram_wr_write, grant); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_data;
        // Pointer sits at 1 after the previous write, so a lone req1 write realigns it to 0.
        req_address = 2'b10; req_writedata = 16'h3300; req_write = 2'b10;
        #1;
        vectors++; if (req_waitrequest !== 2'b01) begin miscompares++; $display("[TB] FAIL lone_req1_wait got %b exp 01", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_writedata, grant} !== {1'b1, 8'h33, 2'b10}) begin
            miscompares++; $display("[TB] FAIL lone_req1_write got w=%b d=%h g=%b exp w=1 d=33 g=10", ram_wr_write, ram_wr_writedata, grant);
        end
        req_writedata = 16'h2211; req_write = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++; if (req_waitrequest !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                miscompares++; $display("[TB] FAIL rr_wait k=%0d got %b", k, req_waitrequest);
            end
            tick();
            exp_data = (k % 2 == 0) ? 8'h11 : 8'h22;
            vectors++; if ({ram_wr_write, ram_wr_writedata, ram_wr_address, grant} !==
                           {1'b1, exp_data, (k % 2 == 0) ? 1'b0 : 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10}) begin
                miscompares++; $display("[TB] FAIL rr_write k=%0d got w=%b d=%h a=%b g=%b exp d=%h", k, ram_wr_write, ram_wr_writedata, ram_wr_address, grant, exp_data);
            end
        end
        req_write = 2'b00;
        tick();
    endtask

    task automatic test_lock_burst();
        logic [7:0] exp_seq [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
        logic [1:0] exp_wait [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        logic       exp_busy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_grant [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [1:0] lock_seq [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
        for (int k = 0; k < 4; k++) begin
            req_writedata = {8'hB0, exp_seq[(k < 3) ? k : 2]};
            req_write     = (k < 3) ? 2'b11 : 2'b10;
            req_lock      = lock_seq[k];
            #1;
            vectors++; if (req_waitrequest !== exp_wait[k]) begin miscompares++; $display("[TB] FAIL lock_wait k=%0d got %b exp %b", k, req_waitrequest, exp_wait[k]); end
            tick();
            vectors++; if ({ram_wr_write, ram_wr_writedata, grant, busy} !== {1'b1, exp_seq[k], exp_grant[k], exp_busy[k]}) begin
                miscompares++; $display("[TB] FAIL lock_write k=%0d got w=%b d=%h g=%b busy=%b exp d=%h g=%b busy=%b", k, ram_wr_write, ram_wr_writedata, grant, busy, exp_seq[k], exp_grant[k], exp_busy[k]);
            end
        end
        req_write = 2'b00;
        tick();
    endtask

    task automatic test_stall();
        req_writedata = 16'h2211; req_write = 2'b11;
        #1;
        vectors++; if (req_waitrequest !== 2'b10) begin miscompares++; $display("[TB] FAIL stall_pre_wait got %b exp 10", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_writedata} !== {1'b1, 8'h11}) begin miscompares++; $display("[TB] FAIL stall_pre_write got w=%b d=%h exp w=1 d=11", ram_wr_write, ram_wr_writedata); end
        ram_wr_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL stall_wait k=%0d got %b exp 11", k, req_waitrequest); end
            tick();
            vectors++; if ({ram_wr_write, grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL stall_write k=%0d got w=%b g=%b exp w=0 g=00", k, ram_wr_write, grant); end
        end
        ram_wr_waitrequest = 1'b0;
        #1;
        vectors++; if (req_waitrequest !== 2'b01) begin miscompares++; $display("[TB] FAIL resume_wait got %b exp 01", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_writedata, grant} !== {1'b1, 8'h22, 2'b10}) begin
            miscompares++; $display("[TB] FAIL resume_write got w=%b d=%h g=%b exp w=1 d=22 g=10", ram_wr_write, ram_wr_writedata, grant);
        end
        #1;
        vectors++; if (req_waitrequest !== 2'b10) begin miscompares++; $display("[TB] FAIL resume2_wait got %b exp 10", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_writedata} !== {1'b1, 8'h11}) begin miscompares++; $display("[TB] FAIL resume2_write got w=%b d=%h exp w=1 d=11", ram_wr_write, ram_wr_writedata); end
        req_write = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        req_address = 2'b10; req_writedata = 16'hC100; req_write = 2'b10; req_lock = 2'b10;
        #1;
        vectors++; if (req_waitrequest !== 2'b01) begin miscompares++; $display("[TB] FAIL mid_lock_wait got %b exp 01", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, grant, busy} !== {1'b1, 2'b10, 1'b1}) begin
            miscompares++; $display("[TB] FAIL mid_lock_held got w=%b g=%b busy=%b exp w=1 g=10 busy=1", ram_wr_write, grant, busy);
        end
        req_write = 2'b00;
        reset_n = 1'b0;
        #1;
        vectors++; if ({busy, grant, ram_wr_write, ram_wr_writedata} !== {1'b0, 2'b00, 1'b0, 8'h00}) begin
            miscompares++; $display("[TB] FAIL async_reset got busy=%b g=%b w=%b d=%h exp all 0", busy, grant, ram_wr_write, ram_wr_writedata);
        end
        vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL async_reset_wait got %b exp 11", req_waitrequest); end
        req_writedata = 16'hD100; req_write = 2'b10; req_lock = 2'b00;
        tick();
        reset_n = 1'b1;
        #1;
        vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL post_reset_wait got %b exp 11", req_waitrequest); end
        tick();
        #1;
        vectors++; if (req_waitrequest !== 2'b01) begin miscompares++; $display("[TB] FAIL post_reset_accept got %b exp 01", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_address, ram_wr_writedata, grant, busy} !== {1'b1, 1'b1, 8'hD1, 2'b10, 1'b0}) begin
            miscompares++; $display("[TB] FAIL post_reset_write got w=%b a=%b d=%h g=%b busy=%b exp w=1 a=1 d=d1 g=10 busy=0", ram_wr_write, ram_wr_address, ram_wr_writedata, grant, busy);
        end
        req_write = 2'b00;
        tick();
    endtask

    task automatic test_lock_timeout();
        req_address = 2'b10; req_writedata = 16'hF1E0; req_write = 2'b11; req_lock = 2'b01;
        #1;
        vectors++; if (req_waitrequest !== 2'b10) begin miscompares++; $display("[TB] FAIL to_lock_wait got %b exp 10", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_writedata, busy} !== {8'hE0, 1'b1}) begin miscompares++; $display("[TB] FAIL to_locked got d=%h busy=%b exp d=e0 busy=1", ram_wr_writedata, busy); end
        req_write = 2'b10;
`ifdef LCD_DFA_ARB_LOCK_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            #1;
            vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL to_idle_wait k=%0d got %b exp 11", k, req_waitrequest); end
            tick();
            vectors++; if ({lock_timeout, busy} !== ((k == 4) ? 2'b10 : 2'b01)) begin
                miscompares++; $display("[TB] FAIL to_pulse k=%0d got pulse=%b busy=%b", k, lock_timeout, busy);
            end
        end
`else
        for (int k = 1; k <= 20; k++) begin
            #1;
            vectors++; if (req_waitrequest !== 2'b11) begin miscompares++; $display("[TB] FAIL hold_wait k=%0d got %b exp 11", k, req_waitrequest); end
            tick();
            vectors++; if ({lock_timeout, busy} !== 2'b01) begin miscompares++; $display("[TB] FAIL hold_lock k=%0d got pulse=%b busy=%b exp pulse=0 busy=1", k, lock_timeout, busy); end
        end
        req_lock = 2'b00;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL release_no_write got busy=%b exp 0", busy); end
`endif
        #1;
        vectors++; if (req_waitrequest !== 2'b01) begin miscompares++; $display("[TB] FAIL to_req1_wait got %b exp 01", req_waitrequest); end
        tick();
        vectors++; if ({ram_wr_write, ram_wr_writedata, grant, lock_timeout} !== {1'b1, 8'hF1, 2'b10, 1'b0}) begin
            miscompares++; $display("[TB] FAIL to_req1_write got w=%b d=%h g=%b pulse=%b exp w=1 d=f1 g=10 pulse=0", ram_wr_write, ram_wr_writedata, grant, lock_timeout);
        end
        req_write = 2'b00; req_lock = 2'b00;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_stall();
        test_reset_mid_lock();
        test_lock_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd_dfa_ram_write_arbiter.md
Name: lcd_dfa_ram_write_arbiter

Overview:
- Shares the single write port of the LCD data-format-adapter lookahead data RAM between NUM_REQ write requesters, e.g. the pixel-unpacking path and the command/config writer.
- Round-robin arbitration with an optional per-requester lock, so a multi-byte burst goes to the RAM without interleaving.
- Holds all requesters off until the RAM deasserts its wr_waitrequest after reset.
- Sits directly in front of the RAM write interface; read ports are untouched.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- ADDR_W, 1, RAM address width.
- DATA_W, 8, RAM data width.
- LOCK_TIMEOUT, 16, idle cycles allowed in LOCKED before forced release (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- req_address  in  NUM_REQ*ADDR_W  per-requester address; requester i in slice [i*ADDR_W +: ADDR_W]
- req_writedata  in  NUM_REQ*DATA_W  per-requester data, sliced the same way
- req_write  in  NUM_REQ  write request; held until accepted
- req_lock  in  NUM_REQ  keep grant after this write
- req_waitrequest  out  NUM_REQ  0 means the write is accepted this cycle
- ram_wr_address  out  ADDR_W  registered RAM address
- ram_wr_writedata  out  DATA_W  registered RAM data
- ram_wr_write  out  1  registered RAM write strobe
- ram_wr_waitrequest  in  1  RAM busy (clearing/reset)
- grant  out  NUM_REQ  registered one-hot owner of the current ram_wr_write
- busy  out  1  1 while in LOCKED
- lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset values:
  - ram_wr_write=0, ram_wr_address=0, ram_wr_writedata=0, grant=0, busy=0, lock_timeout=0.
  - req_waitrequest all 1.
  - rr pointer=0, state=IDLE, ready=0.
- ready: register set on the first clock edge after reset release at which ram_wr_waitrequest=0. Once set it stays set until reset.
- can_accept = ready & !ram_wr_waitrequest. When can_accept=0:
  - all req_waitrequest=1;
  - next ram_wr_write=0;
  - pointer and state unchanged.
- Arbitration is combinational each cycle.
  - IDLE: winner is the first i with req_write[i]=1, scanning from pointer upward and wrapping mod NUM_REQ.
  - LOCKED: winner is the owner only, and only if req_write[owner]=1.
- Accept: req_waitrequest[winner]=0 when can_accept; all others 1. A requester with req_write=0 sees waitrequest=1.
- On accept, at the next edge:
  - ram_wr_write<=1, address and data latched from the winner slice;
  - grant<=onehot(winner);
  - pointer<=(winner+1) mod NUM_REQ.
- No accept: ram_wr_write<=0, grant<=0.
- Write latency: accept at cycle n, RAM write strobe at n+1. Throughput is 1 write per cycle.
- State machine:
  - IDLE->LOCKED(owner=winner): accept with req_lock[winner]=1.
  - LOCKED->IDLE: owner accepted with req_lock=0; or owner has req_lock=0 and req_write=0 (release without a write).
  - LOCKED stays LOCKED otherwise.
- busy = (state==LOCKED).
- Reset mid-burst: everything returns to reset values immediately (asynchronous). A write latched but not yet strobed is dropped.
- NUM_REQ=2 with both requesting continuously gives strict alternation.

Optional Feature:
- Macro: LCD_DFA_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - an idle counter ($clog2(LOCK_TIMEOUT+1) bits) clears on entering LOCKED and on every owner accept;
  - it increments each LOCKED cycle with no owner accept;
  - when it reaches LOCK_TIMEOUT, state goes to IDLE at that edge, lock_timeout pulses 1 for one cycle, and the pointer moves to owner+1.
- Not defined: no counter; a lock is held indefinitely; lock_timeout is tied to 0.

Test Plan:
- Reset/ready: hold reset_n=0 with ram_wr_waitrequest=1 -> req_waitrequest=2'b11, ram_wr_write=0. Release reset, drop ram waitrequest, then req_write[0]=1, addr 0, data 0x5A -> next cycle ram_wr_write=1, address 0, data 0x5A, grant=2'b01.
- Round-robin: both requesters write continuously (req0 data 0x11, req1 data 0x22) -> RAM data 0x11,0x22,0x11,0x22; each req_waitrequest low on alternate cycles.
- Lock burst: req0 writes 0xA0,0xA1,0xA2 with req_lock=1,1,0 while req1 requests 0xB0 throughout -> RAM sequence A0,A1,A2,B0; busy=1 for the cycles after the first accept through the last.
- Stall: ram_wr_waitrequest=1 for 3 cycles mid-traffic -> no ram_wr_write, all req_waitrequest=1; alternation resumes with the requester that was next.
- Reset mid-lock: assert reset_n=0 while busy=1 -> busy=0, grant=0 immediately. After release, req1 alone requesting is granted on its first accept.
- Timeout: with LCD_DFA_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=4, req0 locks then idles with req_lock=1 while req1 requests -> lock_timeout pulse after 4 idle cycles, busy=0, req1 accepted the next cycle. Without the macro, req1 is still waiting after 20 cycles.
